// File: rtl/btn_evt_pkg.sv
// Package btn_evt_pkg
// Shared definitions for the button event decoder and its consumers:
// the FSM state encoding, the bit positions of each event inside the
// registered event vector, and a helper that sizes the shared counter.
package btn_evt_pkg;

    // FSM state encoding, kept as plain constants so it maps directly
    // onto legacy consumers and debug buses.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_DOWN1 = 3'd1;
    localparam state_t ST_GAP   = 3'd2;
    localparam state_t ST_DOWN2 = 3'd3;
    localparam state_t ST_LONG  = 3'd4;

    // Event-bit indices inside the registered event vector.
    localparam int EVT_PRESS   = 0;
    localparam int EVT_RELEASE = 1;
    localparam int EVT_SHORT   = 2;
    localparam int EVT_DOUBLE  = 3;
    localparam int EVT_LONG    = 4;
    localparam int EVT_REPEAT  = 5;
    localparam int EVT_W       = 6;

    // Counter width: $clog2 of the largest timing parameter, at least 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m <= 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/button_edge_detector.sv
// Module button_edge_detector
// Holds the previous sample of the debounced button level and derives the
// rise/fall strobes from it. The previous sample doubles as the registered
// "held" level, so held and the edge strobes can never disagree.
module button_edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_db,
    output logic rise,
    output logic fall,
    output logic held
);

    logic btn_prev;

    // Previous-sample register; cleared so a button held through reset
    // produces a rise on the first active cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_prev <= 1'b0;
        end else begin
            btn_prev <= btn_db;
        end
    end

    assign rise = btn_db & ~btn_prev;
    assign fall = ~btn_db & btn_prev;
    assign held = btn_prev;

endmodule

// File: rtl/button_event_decoder.sv
// Module button_event_decoder
// Classifies the debounced button level into single-cycle events:
// press, release, short click, double click, long press and, when the
// BTN_EVT_AUTOREPEAT_EN macro is defined, auto-repeat while long-held.
// Without the macro repeat_pulse is constant 0 and LONG only waits for
// release. All event outputs are registered; an edge sampled at clock N
// shows up on the outputs right after clock N. One saturating counter
// serves every timing window and is cleared on each state change.
// state_dbg exposes the current FSM state for observation.
module button_event_decoder
    import btn_evt_pkg::*;
#(
    parameter int LONG_PRESS_CLK_CNT = 1048576,
    parameter int DBL_GAP_CLK_CNT    = 262144,
    parameter int REPEAT_CLK_CNT     = 131072
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   btn_db,
    output logic   held,
    output logic   press_pulse,
    output logic   release_pulse,
    output logic   short_click,
    output logic   double_click,
    output logic   long_press,
    output logic   repeat_pulse,
    output state_t state_dbg
);

    localparam int CNT_W = cnt_width(LONG_PRESS_CLK_CNT, DBL_GAP_CLK_CNT, REPEAT_CLK_CNT);

    // Counter values on the last cycle of each window; the event fires on
    // the clock that sees these values, which places it exactly N cycles
    // after the pulse that opened the window.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CLK_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CLK_CNT - 1);
`ifdef BTN_EVT_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CLK_CNT - 1);
`endif

    logic              rise;
    logic              fall;
    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_clear;
    logic [EVT_W-1:0]  evt_next;
    logic [EVT_W-1:0]  evt_q;

    button_edge_detector u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_db (btn_db),
        .rise   (rise),
        .fall   (fall),
        .held   (held)
    );

    // Next-state and event decode; edge pulses pass through in every state.
    always_comb begin
        state_next            = state;
        evt_next              = '0;
        cnt_clear             = 1'b0;
        evt_next[EVT_PRESS]   = rise;
        evt_next[EVT_RELEASE] = fall;

        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_next = ST_DOWN1;
                end
            end
            ST_DOWN1: begin
                if (fall) begin
                    state_next = ST_GAP;
                end else if (cnt == LONG_LAST) begin
                    evt_next[EVT_LONG] = 1'b1;
                    state_next         = ST_LONG;
                end
            end
            ST_GAP: begin
                // A second press arriving on the expiry cycle still counts
                // as a double-click candidate.
                if (rise) begin
                    state_next = ST_DOWN2;
                end else if (cnt == GAP_LAST) begin
                    evt_next[EVT_SHORT] = 1'b1;
                    state_next          = ST_IDLE;
                end
            end
            ST_DOWN2: begin
                // Going long here drops the pending click entirely.
                if (fall) begin
                    evt_next[EVT_DOUBLE] = 1'b1;
                    state_next           = ST_IDLE;
                end else if (cnt == LONG_LAST) begin
                    evt_next[EVT_LONG] = 1'b1;
                    state_next         = ST_LONG;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_next = ST_IDLE;
                end
`ifdef BTN_EVT_AUTOREPEAT_EN
                else if (cnt == REP_LAST) begin
                    evt_next[EVT_REPEAT] = 1'b1;
                    cnt_clear            = 1'b1;
                end
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (state_next != state) begin
            cnt_clear = 1'b1;
        end
    end

    // State, counter and event registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            evt_q <= '0;
        end else begin
            state <= state_next;
            evt_q <= evt_next;
            if (cnt_clear) begin
                cnt <= '0;
            end else if (cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press_pulse   = evt_q[EVT_PRESS];
    assign release_pulse = evt_q[EVT_RELEASE];
    assign short_click   = evt_q[EVT_SHORT];
    assign double_click  = evt_q[EVT_DOUBLE];
    assign long_press    = evt_q[EVT_LONG];
    assign repeat_pulse  = evt_q[EVT_REPEAT];
    assign state_dbg     = state;

endmodule

// File: tb/tb_button_event_decoder.sv
// Testbench for button_event_decoder with LONG=16, GAP=8, REPEAT=4.
// Expected output vector per step: {held, press, release, short, double, long, repeat}.
// Repeat expectations follow BTN_EVT_AUTOREPEAT_EN.
module tb_button_event_decoder;
    import btn_evt_pkg::*;

    localparam int LONG_N = 16;
    localparam int GAP_N  = 8;
    localparam int REP_N  = 4;

`ifdef BTN_EVT_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    localparam logic [6:0] Z  = 7'b0000000;
    localparam logic [6:0] H  = 7'b1000000;
    localparam logic [6:0] P  = 7'b0100000;
    localparam logic [6:0] R  = 7'b0010000;
    localparam logic [6:0] S  = 7'b0001000;
    localparam logic [6:0] D  = 7'b0000100;
    localparam logic [6:0] L  = 7'b0000010;
    localparam logic [6:0] RP = 7'b0000001;

    // Clock and reset
    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic btn_db = 1'b0;
    always #5 clk = ~clk;

    logic   held, press_pulse, release_pulse, short_click;
    logic   double_click, long_press, repeat_pulse;
    state_t state_dbg;

    button_event_decoder #(
        .LONG_PRESS_CLK_CNT (LONG_N),
        .DBL_GAP_CLK_CNT    (GAP_N),
        .REPEAT_CLK_CNT     (REP_N)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_db        (btn_db),
        .held          (held),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_click   (short_click),
        .double_click  (double_click),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .state_dbg     (state_dbg)
    );

    typedef struct {
        logic       rst;
        logic       btn;
        logic [6:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] exp_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;

    function automatic logic [6:0] outs();
        return {held, press_pulse, release_pulse, short_click,
                double_click, long_press, repeat_pulse};
    endfunction

    // Driver tasks
    task automatic add(input logic r, input logic b, input logic [6:0] e);
        vec_t v;
        v.rst = r;
        v.btn = b;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input logic r, input logic b, input logic [6:0] e);
        for (int k = 0; k < n; k++) add(r, b, e);
    endtask

    task automatic drive(input logic r, input logic b);
        rst_n  = r;
        btn_db = b;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard compare
    task automatic check7(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (held,press,rel,short,dbl,long,rep)",
                     name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input state_t exp);
        n_cmp++;
        if (state_dbg !== exp) begin
            n_fail++;
            $display("FAIL %s: state got %0d expected %0d", name, state_dbg, exp);
        end
    endtask

    // Drive btn for one step and compare against the oldest queued expectation.
    task automatic step_q(input string name, input logic b);
        logic [6:0] e;
        drive(1'b1, b);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: expectation queue empty", name);
        end else begin
            e = exp_q.pop_front();
            check7(name, outs(), e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with button pressed, then press_pulse on the first active cycle.
        add_n(3, 1'b0, 1'b1, Z);
        add(1'b1, 1'b1, H | P);
        add(1'b1, 1'b0, R);
        add_n(GAP_N - 1, 1'b1, 1'b0, Z);
        add(1'b1, 1'b0, S);
        add_n(4, 1'b1, 1'b0, Z);

        // Hold 5, release, short_click GAP cycles after release_pulse.
        add(1'b1, 1'b1, H | P);
        add_n(4, 1'b1, 1'b1, H);
        add(1'b1, 1'b0, R);
        add_n(GAP_N - 1, 1'b1, 1'b0, Z);
        add(1'b1, 1'b0, S);
        add_n(8, 1'b1, 1'b0, Z);

        // Press 3, release 3, press 3, release -> double click, no short click.
        add(1'b1, 1'b1, H | P);
        add_n(2, 1'b1, 1'b1, H);
        add(1'b1, 1'b0, R);
        add_n(2, 1'b1, 1'b0, Z);
        add(1'b1, 1'b1, H | P);
        add_n(2, 1'b1, 1'b1, H);
        add(1'b1, 1'b0, R | D);
        add_n(12, 1'b1, 1'b0, Z);

        // Second press on the exact cycle the gap expires: rise wins.
        add(1'b1, 1'b1, H | P);
        add(1'b1, 1'b0, R);
        add_n(GAP_N - 1, 1'b1, 1'b0, Z);
        add(1'b1, 1'b1, H | P);
        add_n(2, 1'b1, 1'b1, H);
        add(1'b1, 1'b0, R | D);
        add_n(12, 1'b1, 1'b0, Z);

        // Second press one cycle too late: short click, then a fresh single click.
        add(1'b1, 1'b1, H | P);
        add(1'b1, 1'b0, R);
        add_n(GAP_N - 1, 1'b1, 1'b0, Z);
        add(1'b1, 1'b0, S);
        add(1'b1, 1'b1, H | P);
        add(1'b1, 1'b0, R);
        add_n(GAP_N - 1, 1'b1, 1'b0, Z);
        add(1'b1, 1'b0, S);
        add_n(3, 1'b1, 1'b0, Z);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].btn);
            check7($sformatf("vec%0d", i), outs(), vecs[i].exp);
            if (i == 0) check_state("reset_state", ST_IDLE);
        end

        // Long hold of 30 cycles: long_press LONG_N after press_pulse,
        // repeats every REP_N after that only with auto-repeat built in.
        exp_q.push_back(H | P);
        for (int k = 1; k < 30; k++) begin
            logic [6:0] e;
            e = H;
            if (k == LONG_N) e = e | L;
            if (AUTOREP && k > LONG_N && ((k - LONG_N) % REP_N) == 0) e = e | RP;
            exp_q.push_back(e);
        end
        exp_q.push_back(R);
        for (int k = 0; k < 12; k++) exp_q.push_back(Z);
        for (int k = 0; k < 30; k++) begin
            step_q($sformatf("long_hold%0d", k), 1'b1);
            if (k == LONG_N + 1) check_state("long_state", ST_LONG);
        end
        step_q("long_release", 1'b0);
        check_state("long_release_state", ST_IDLE);
        for (int k = 0; k < 12; k++) step_q($sformatf("long_after%0d", k), 1'b0);

        // Second press held to the long threshold: long_press, click discarded.
        exp_q.push_back(H | P);
        exp_q.push_back(R);
        exp_q.push_back(H | P);
        for (int k = 1; k <= LONG_N + 2; k++) exp_q.push_back((k == LONG_N) ? (H | L) : H);
        exp_q.push_back(R);
        for (int k = 0; k < 12; k++) exp_q.push_back(Z);
        step_q("d2l_press1", 1'b1);
        step_q("d2l_release1", 1'b0);
        step_q("d2l_press2", 1'b1);
        check_state("d2l_down2_state", ST_DOWN2);
        for (int k = 1; k <= LONG_N + 2; k++) step_q($sformatf("d2l_hold%0d", k), 1'b1);
        step_q("d2l_release2", 1'b0);
        for (int k = 0; k < 12; k++) step_q($sformatf("d2l_after%0d", k), 1'b0);

        // Reset asserted mid-press clears everything.
        drive(1'b1, 1'b1);
        check7("midrst_press", outs(), H | P);
        drive(1'b0, 1'b1);
        check7("midrst_reset", outs(), Z);
        check_state("midrst_state", ST_IDLE);
        drive(1'b1, 1'b1);
        check7("midrst_repress", outs(), H | P);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL leftover_exp: %0d entries remain, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
